// File: rtl/key_pulse_debouncer.sv
// key_pulse_debouncer: turns a raw, bouncing, active-low push-button into a
// clean one-cycle enable pulse in the clk domain, with optional auto-repeat
// while the button is held. The pressed output is the debounced level.
module key_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic sclr,
  input  logic key_n,
  output logic pulse,
  output logic pressed
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  // Terminal counts: a counter equal to these has seen N cycles.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_rcnt;
  logic             r_rphase;
  logic             r_pulse;
  logic             r_pressed;

  logic             w_key_s;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_dcnt_nxt;
  logic [CNT_W-1:0] w_rcnt_nxt;
  logic             w_rphase_nxt;
  logic             w_pulse_nxt;
  logic             w_pressed_nxt;
  logic [CNT_W-1:0] w_rep_last;

  // Synchronized, active-high view of the button (1 = pressed).
  assign w_key_s = r_sync2;

  // First repeat waits the long delay, later ones use the shorter period.
  assign w_rep_last = r_rphase ? PERIOD_LAST : DELAY_LAST;

  // Next-state and counter logic for the debounce / auto-repeat FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_rcnt_nxt   = r_rcnt;
    w_rphase_nxt = r_rphase;
    w_pulse_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_state_nxt = S_PRESS_WAIT;
          w_dcnt_nxt  = '0;
        end
      end

      S_PRESS_WAIT: begin
        if (!w_key_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt  = S_PRESSED;
          w_pulse_nxt  = 1'b1;
          w_rcnt_nxt   = '0;
          w_rphase_nxt = 1'b0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end

      S_PRESSED: begin
        if (!w_key_s) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_dcnt_nxt  = '0;
        end else if (REPEAT_EN != 0) begin
          if (r_rcnt == w_rep_last) begin
            w_pulse_nxt  = 1'b1;
            w_rcnt_nxt   = '0;
            w_rphase_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end

      S_RELEASE_WAIT: begin
        // A bounce back to pressed restarts the repeat delay without a pulse.
        if (w_key_s) begin
          w_state_nxt  = S_PRESSED;
          w_rcnt_nxt   = '0;
          w_rphase_nxt = 1'b0;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // pressed tracks the next state so it changes on the same edge as the state.
  assign w_pressed_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_WAIT);

  // Synchronizer, FSM and output registers; sclr overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (sclr) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= S_IDLE;
      r_dcnt    <= '0;
      r_rcnt    <= '0;
      r_rphase  <= 1'b0;
      r_pulse   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_sync1   <= ~key_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rphase  <= w_rphase_nxt;
      r_pulse   <= w_pulse_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  assign pulse   = r_pulse;
  assign pressed = r_pressed;

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Testbench for key_pulse_debouncer: two instances (auto-repeat off and on)
// share one stimulus; a level/run-length reference model predicts both.
module tb_key_pulse_debouncer;

  localparam int DB  = 4;
  localparam int DLY = 8;
  localparam int PER = 3;

  logic clk;
  logic sclr;
  logic key_n;
  logic pulse_n, pressed_n;
  logic pulse_r, pressed_r;

  key_pulse_debouncer #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER), .CNT_W(4)
  ) dut_norep (
    .clk(clk), .sclr(sclr), .key_n(key_n), .pulse(pulse_n), .pressed(pressed_n)
  );

  key_pulse_debouncer #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER), .CNT_W(4)
  ) dut_rep (
    .clk(clk), .sclr(sclr), .key_n(key_n), .pulse(pulse_r), .pressed(pressed_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: debounced level, length of the current disagreeing run,
  // and edges spent held since the last pulse or repeat restart.
  typedef struct {
    bit held;
    int run;
    int t;
    bit phase;
    bit pulse;
  } model_t;

  model_t m[2];
  bit     raw_q[$];     // two-edge delay line of the pressed sense of key_n
  int     vectors = 0;
  int     miscompares = 0;
  int     e;            // edge index within the current scenario
  int     pe_n[$];      // edges after which each DUT pulsed
  int     pe_r[$];
  int     exp_q[$];     // expected pulse edges for the repeat instance
  logic   prev_pulse_r, prev_pulse_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    raw_q.delete();
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      m[i].held  = 1'b0;
      m[i].run   = 0;
      m[i].t     = 0;
      m[i].phase = 1'b0;
      m[i].pulse = 1'b0;
    end
  endfunction

  // A level change is accepted after DB+1 consecutive disagreeing edges.
  function automatic void model_step(input int i, input bit ks, input bit rep_en);
    m[i].pulse = 1'b0;
    if (!m[i].held) begin
      if (ks) begin
        m[i].run++;
        if (m[i].run == DB + 1) begin
          m[i].held  = 1'b1;
          m[i].run   = 0;
          m[i].pulse = 1'b1;
          m[i].t     = 0;
          m[i].phase = 1'b0;
        end
      end else begin
        m[i].run = 0;
      end
    end else begin
      if (!ks) begin
        m[i].run++;
        if (m[i].run == DB + 1) begin
          m[i].held = 1'b0;
          m[i].run  = 0;
        end
      end else if (m[i].run != 0) begin
        m[i].run   = 0;
        m[i].t     = 0;
        m[i].phase = 1'b0;
      end else if (rep_en) begin
        m[i].t++;
        if (m[i].t == (m[i].phase ? PER : DLY)) begin
          m[i].pulse = 1'b1;
          m[i].t     = 0;
          m[i].phase = 1'b1;
        end
      end
    end
  endfunction

  // One clock edge: advance the model, then compare both DUTs after the edge.
  task automatic tick();
    bit ks;
    @(posedge clk);
    if (sclr) begin
      model_reset();
    end else begin
      ks = raw_q.pop_front();
      raw_q.push_back(~key_n);
      model_step(0, ks, 1'b0);
      model_step(1, ks, 1'b1);
    end
    #1;
    if (pulse_n === 1'b1) pe_n.push_back(e);
    if (pulse_r === 1'b1) pe_r.push_back(e);
    check("pulse_norep",   pulse_n,   m[0].pulse);
    check("pressed_norep", pressed_n, m[0].held);
    check("pulse_rep",     pulse_r,   m[1].pulse);
    check("pressed_rep",   pressed_r, m[1].held);
    check("pulse_consecutive", (pulse_r & prev_pulse_r) | (pulse_n & prev_pulse_n), 0);
    prev_pulse_r = pulse_r;
    prev_pulse_n = pulse_n;
    e++;
  endtask

  task automatic start_scn();
    e = 0;
    pe_n.delete();
    pe_r.delete();
    exp_q.delete();
  endtask

  // Repeat pulses every PER edges from first, while the key is still seen held.
  task automatic add_train(input int first, input int last_ok);
    for (int x = first; x <= last_ok; x += PER) exp_q.push_back(x);
  endtask

  task automatic check_rep(input string tag);
    check({tag, "_rep_count"}, pe_r.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pe_r.size(); k++)
      check({tag, "_rep_edge"}, pe_r[k], exp_q[k]);
  endtask

  task automatic check_norep(input string tag, input int press_edge);
    check({tag, "_norep_count"}, pe_n.size(), 1);
    if (pe_n.size() > 0) check({tag, "_norep_edge"}, pe_n[0], press_edge);
  endtask

  // Release the key, let the FSM settle, and clear for one edge.
  task automatic settle();
    key_n = 1'b1;
    repeat (8) tick();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
  endtask

  initial begin
    prev_pulse_r = 1'b0;
    prev_pulse_n = 1'b0;
    e = 0;
    model_reset();
    sclr  = 1'b1;
    key_n = 1'b1;
    repeat (2) tick();
    check("reset_pulse",   pulse_r,   0);
    check("reset_pressed", pressed_r, 0);

    // Key held through sclr: nothing during clear, then one full debounce.
    key_n = 1'b0;
    repeat (3) begin
      tick();
      check("s1_sclr_pulse",   pulse_r | pulse_n, 0);
      check("s1_sclr_pressed", pressed_r | pressed_n, 0);
    end
    sclr = 1'b0;
    start_scn();
    repeat (10) tick();
    key_n = 1'b1;
    repeat (12) tick();
    exp_q.push_back(6);
    check_rep("s1");
    check_norep("s1", 6);
    settle();

    // Long hold: single pulse without repeat, press + repeat train with it.
    start_scn();
    key_n = 1'b0;
    repeat (40) tick();
    key_n = 1'b1;
    repeat (5) tick();
    tick();
    check("s2_pressed_e45", pressed_n, 1);
    tick();
    check("s2_pressed_e46", pressed_n, 0);
    repeat (9) tick();
    exp_q.push_back(6);
    add_train(6 + DLY, 41);
    check_rep("s2");
    check_norep("s2", 6);
    settle();

    // Bounce shorter than the debounce window is rejected.
    start_scn();
    key_n = 1'b0; tick();
    key_n = 1'b1; tick();
    key_n = 1'b0; tick();
    key_n = 1'b0; tick();
    key_n = 1'b1; tick();
    repeat (12) tick();
    check("s3_pulses_rep",   pe_r.size(), 0);
    check("s3_pulses_norep", pe_n.size(), 0);
    settle();

    // Release glitch: pressed holds, repeat delay restarts on the return.
    start_scn();
    key_n = 1'b0;
    repeat (30) tick();
    key_n = 1'b1;
    repeat (2) tick();
    key_n = 1'b0;
    repeat (2) tick();
    check("s5_pressed_glitch", pressed_r, 1);
    repeat (15) tick();
    key_n = 1'b1;
    repeat (12) tick();
    exp_q.push_back(6);
    add_train(6 + DLY, 31);
    add_train(34 + DLY, 50);
    check_rep("s5");
    check_norep("s5", 6);
    settle();

    // sclr mid press-wait restarts the debounce from scratch.
    start_scn();
    key_n = 1'b0;
    repeat (5) tick();
    sclr = 1'b1;
    tick();
    check("s6_sclr_pressed", pressed_r, 0);
    sclr = 1'b0;
    repeat (12) tick();
    key_n = 1'b1;
    repeat (12) tick();
    exp_q.push_back(12);
    check_rep("s6");
    check_norep("s6", 12);
    settle();

    // Random runs of key levels with occasional clears, checked by the model.
    start_scn();
    repeat (250) begin
      int len;
      len   = $urandom_range(1, 12);
      key_n = 1'($urandom_range(0, 1));
      sclr  = ($urandom_range(0, 40) == 0);
      repeat (len) begin
        tick();
        sclr = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
